// File: rtl/cond_pkg.sv
// Shared types and constants for the pipelined condition unit.
// Flag bit positions follow the {N,Z,C,V} packing used by the ALU.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef logic [3:0] flags_t;

  // Expand a per-group enable vector (zero-extended to 4 bits) into a per-flag-bit mask.
  function automatic flags_t grp_mask(input logic [3:0] we, input int ngrp);
    flags_t m;
    m = '0;
    for (int b = 0; b < 4; b++) m[b] = we[2'((b * ngrp) / 4)];
    return m;
  endfunction

endpackage

// File: rtl/condunit_pipe_if.sv
// Pipeline-side bundle of the condition unit: E-stage controls in, gated enables and state out.
interface condunit_pipe_if #(
  parameter int NGRP = 2,
  parameter int CNTW = 16
);
  logic [3:0]      iCondE;
  logic [3:0]      iALUFlagsE;
  logic [NGRP-1:0] iFlagWE;
  logic            iPCSE;
  logic            iRegWE;
  logic            iMemWE;
  logic            iStallE;
  logic            iFlushE;
  logic            iSaveFlags;
  logic            iRestoreFlags;
  logic            iCntClr;
  logic            oCondExE;
  logic            oPCSrcE;
  logic            oRegWriteM;
  logic            oMemWriteM;
  logic            oCondUndefM;
  logic [3:0]      oFlags;
  logic [CNTW-1:0] oSkipCnt;

  modport slave (
    input  iCondE, iALUFlagsE, iFlagWE, iPCSE, iRegWE, iMemWE, iStallE, iFlushE,
           iSaveFlags, iRestoreFlags, iCntClr,
    output oCondExE, oPCSrcE, oRegWriteM, oMemWriteM, oCondUndefM, oFlags, oSkipCnt
  );

  modport master (
    output iCondE, iALUFlagsE, iFlagWE, iPCSE, iRegWE, iMemWE, iStallE, iFlushE,
           iSaveFlags, iRestoreFlags, iCntClr,
    input  oCondExE, oPCSrcE, oRegWriteM, oMemWriteM, oCondUndefM, oFlags, oSkipCnt
  );
endinterface

// File: rtl/condunit_pipe_cond_eval.sv
// Combinational evaluation of a 4-bit condition field against NZCV flags.
// The reserved encoding never executes and is reported separately.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] iCond,
  input  flags_t     iFlags,
  output logic       oCondEx,
  output logic       oUndef
);
  logic w_n, w_z, w_c, w_v, w_ge;

  assign w_n  = iFlags[N_IDX];
  assign w_z  = iFlags[Z_IDX];
  assign w_c  = iFlags[C_IDX];
  assign w_v  = iFlags[V_IDX];
  assign w_ge = (w_n == w_v);

  always_comb begin
    oCondEx = 1'b0;
    case (iCond)
      EQ:      oCondEx = w_z;
      NE:      oCondEx = ~w_z;
      CS:      oCondEx = w_c;
      CC:      oCondEx = ~w_c;
      MI:      oCondEx = w_n;
      PL:      oCondEx = ~w_n;
      VS:      oCondEx = w_v;
      VC:      oCondEx = ~w_v;
      HI:      oCondEx = w_c & ~w_z;
      LS:      oCondEx = ~(w_c & ~w_z);
      GE:      oCondEx = w_ge;
      LT:      oCondEx = ~w_ge;
      GT:      oCondEx = ~w_z & w_ge;
      LE:      oCondEx = ~(~w_z & w_ge);
      AL:      oCondEx = 1'b1;
      default: oCondEx = 1'b0;
    endcase
  end

  assign oUndef = (iCond == NV);
endmodule

// File: rtl/condunit_pipe.sv
// Pipelined conditional-execution unit: qualifies E-stage writes, owns the flags,
// the shadow flags, the M-stage enable register and the annulled-instruction counter.
module condunit_pipe
  import cond_pkg::*;
#(
  parameter int NGRP       = 2,
  parameter int CNTW       = 16,
  parameter int UNDEF_TRAP = 1
) (
  input logic              iClk,
  input logic              iReset,
  condunit_pipe_if.slave   bus
);
  localparam logic TRAP = (UNDEF_TRAP != 0);

  flags_t          r_flags;
  flags_t          r_shadow;
  logic            r_reg_wr_m;
  logic            r_mem_wr_m;
  logic            r_undef_m;
  logic [CNTW-1:0] r_cnt;

  logic   w_raw;
  logic   w_undef;
  logic   w_qual;
  logic   w_adv;
  flags_t w_mask;

  cond_eval u_cond_eval (
    .iCond   (bus.iCondE),
    .iFlags  (r_flags),
    .oCondEx (w_raw),
    .oUndef  (w_undef)
  );

  assign w_qual = w_raw & ~bus.iFlushE;
  assign w_adv  = ~bus.iFlushE & ~bus.iStallE;
  // A stalled instruction is re-evaluated next cycle, so it must not touch the flags yet.
  assign w_mask = grp_mask(4'(bus.iFlagWE), NGRP) & {4{w_qual & ~bus.iStallE}};

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_flags  <= '0;
      r_shadow <= '0;
    end else begin
      if (bus.iRestoreFlags) r_flags <= r_shadow;
      else                   r_flags <= (r_flags & ~w_mask) | (bus.iALUFlagsE & w_mask);
      if (bus.iSaveFlags)    r_shadow <= r_flags;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_reg_wr_m <= 1'b0;
      r_mem_wr_m <= 1'b0;
      r_undef_m  <= 1'b0;
    end else begin
      r_reg_wr_m <= w_adv & bus.iRegWE & w_qual;
      r_mem_wr_m <= w_adv & bus.iMemWE & w_qual;
      r_undef_m  <= w_adv & TRAP & w_undef;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset)                          r_cnt <= '0;
    else if (bus.iCntClr)                r_cnt <= '0;
    else if (w_adv & ~w_raw & ~&r_cnt)   r_cnt <= r_cnt + 1'b1;
  end

  assign bus.oCondExE    = w_qual;
  assign bus.oPCSrcE     = bus.iPCSE & w_qual;
  assign bus.oRegWriteM  = r_reg_wr_m;
  assign bus.oMemWriteM  = r_mem_wr_m;
  assign bus.oCondUndefM = r_undef_m;
  assign bus.oFlags      = r_flags;
  assign bus.oSkipCnt    = r_cnt;
endmodule

// File: doc/condunit_pipe.md
Name: condunit_pipe

Overview:
Parametrised pipelined successor of the single-cycle conditional-execution logic for the ARM-subset core. Evaluates the 4-bit condition field of the Execute-stage instruction against the architectural NZCV flags, gates the register, memory and PC writes, and updates the flags through per-group write masks. Adds stall/flush handling, a registered Memory-stage write-enable stage, a shadow flag register for exception save/restore, defined behaviour for the reserved condition, and a saturating annulled-instruction counter.

Parameters:
NGRP, 2, number of independently writable flag groups; legal values 1, 2, 4; group g covers flag bits [(g+1)*4/NGRP-1 : g*4/NGRP]
CNTW, 16, width of the annulled-instruction counter
UNDEF_TRAP, 1, 1 = condition 4'b1111 raises oCondUndefM; 0 = 4'b1111 treated as never-execute with no flag

Ports:
iClk  in  1  core clock, all state on rising edge
iReset  in  1  asynchronous, active-high reset
iCondE  in  4  condition field of E-stage instruction
iALUFlagsE  in  4  {N,Z,C,V} from E-stage ALU
iFlagWE  in  NGRP  per-group flag write request (bit NGRP-1 = group holding N)
iPCSE  in  1  instruction writes PC
iRegWE  in  1  instruction writes register file
iMemWE  in  1  instruction writes memory
iStallE  in  1  E stage held this cycle
iFlushE  in  1  E-stage instruction is a bubble
iSaveFlags  in  1  copy flags to shadow (exception entry)
iRestoreFlags  in  1  copy shadow to flags (exception return)
iCntClr  in  1  synchronous clear of counter
oCondExE  out  1  qualified condition result, combinational
oPCSrcE  out  1  iPCSE & qualified CondEx, combinational
oRegWriteM  out  1  registered iRegWE & qualified CondEx
oMemWriteM  out  1  registered iMemWE & qualified CondEx
oCondUndefM  out  1  registered reserved-condition indication
oFlags  out  4  architectural {N,Z,C,V}
oSkipCnt  out  CNTW  annulled-instruction count

Behaviour:
- Reset (async, any cycle, mid-operation included): Flags=0, shadow=0, oRegWriteM=oMemWriteM=oCondUndefM=0, oSkipCnt=0. Combinational outputs follow from Flags=0 and inputs.
- Raw CondEx from current Flags (registered value, no bypass): EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~(C&~Z); GE N==V; LT N!=V; GT ~Z&GE; LE ~(~Z&GE); AL 1; 4'b1111 → 0 (never x).
- Qualified CondEx = raw & ~iFlushE. oPCSrcE = iPCSE & qualified, 0 latency.
- Flag update: group g written when iFlagWE[g] & qualified & ~iStallE. Unwritten groups hold.
- Priority on Flags: iRestoreFlags > flag write > hold. Restore and write in same cycle: shadow value loaded, ALU flags discarded.
- Shadow: iSaveFlags loads pre-update Flags (value at start of cycle); save+restore same cycle: Flags<=shadow, shadow<=old Flags (swap).
- M-stage register, 1-cycle latency: if iFlushE load 0s; else if iStallE load 0s (bubble into M, E instruction re-evaluated next cycle); else load iRegWE&qualified, iMemWE&qualified, (UNDEF_TRAP & iCondE==4'b1111).
- Flush and stall together: flush wins (no flag write, zeros into M, no count).
- Counter: increments when ~iFlushE & ~iStallE & raw CondEx==0; saturates at 2^CNTW-1. iCntClr wins over increment (result 0).
- NGRP=1: single enable writes all four bits; NGRP=4: per-bit enables.
- Reserved condition with UNDEF_TRAP=0: annulled, counted, oCondUndefM stays 0.

Decomposition:
- Package cond_pkg: cond_e enum (EQ..AL, NV=4'b1111), flag bit index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0, flags_t typedef.
- One combinational sub-module cond_eval (iCond, iFlags → oCondEx, oUndef); condunit_pipe holds all state, masks, M register, counter.

Test Plan:
- Reset mid-stream with Flags=4'b1111, oSkipCnt=5 → all outputs/state 0 immediately, before next edge.
- Flags Z=1, iCondE=EQ, iRegWE=1, iFlagWE=2'b11, iALUFlagsE=4'b0010 → oCondExE=1 same cycle, oRegWriteM=1 next cycle, oFlags=4'b0010 next cycle.
- Flags=0, iCondE=EQ, iMemWE=1, iPCSE=1 → oPCSrcE=0, oMemWriteM=0, oFlags unchanged, oSkipCnt +1.
- NGRP=2, iFlagWE=2'b01, iCondE=AL, Flags=4'b1100, ALU=4'b0011 → oFlags=4'b1111.
- iFlushE=1 and iStallE=1 with AL, iFlagWE=2'b11, iRegWE=1 → no flag change, oRegWriteM=0, counter unchanged; iCondE=4'b1111 unstalled with UNDEF_TRAP=1 → oCondUndefM=1 next cycle, counter +1.
- Save at Flags=4'b1000, then write 4'b0100, then restore together with AL flag write 4'b0001 → oFlags=4'b1000; CNTW=2 with 5 annulled instructions → oSkipCnt=3, iCntClr together with annulled instruction → 0.
